// File: rtl/keypad_events.sv
// Debounces the scanned 16-key matrix and provides the key-press query and the
// blocking wait-for-key handshake used by the instruction executor.
module keypad_events #(
  parameter int unsigned SAMPLE_DIV     = 1024,
  parameter int unsigned STABLE_SAMPLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] matrix,
  output logic [15:0] keys,
  input  logic [3:0]  query_key,
  output logic        query_pressed,
  input  logic        wait_req,
  output logic        wait_busy,
  output logic        wait_done,
  output logic [3:0]  wait_key
);

  localparam int unsigned DivW = $clog2(SAMPLE_DIV);
  localparam int unsigned CntW = $clog2(STABLE_SAMPLES) + 1;

  typedef enum logic [1:0] {StIdle, StArmed, StHeld, StDone} state_e;

  logic [DivW-1:0] div_q, div_d;
  logic            tick;
  logic [CntW-1:0] cnt_q [16];
  logic [CntW-1:0] cnt_d [16];
  logic [15:0]     keys_q, keys_d;
  logic [15:0]     keys_prev_q;
  logic [15:0]     rise, fall;
  logic [3:0]      cap_q, cap_d;
  logic [3:0]      wait_key_q, wait_key_d;
  logic [3:0]      rise_low;
  state_e          state_q, state_d;

  // Sample divider
  always_comb begin
    tick  = (div_q == DivW'(SAMPLE_DIV - 1));
    div_d = tick ? '0 : div_q + 1'b1;
  end

  // Per-key debounce: any agreeing sample discards partial progress.
  always_comb begin
    keys_d = keys_q;
    for (int i = 0; i < 16; i++) begin
      cnt_d[i] = cnt_q[i];
      if (tick) begin
        if (matrix[i] == keys_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CntW'(STABLE_SAMPLES - 1)) begin
          keys_d[i] = matrix[i];
          cnt_d[i]  = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    rise     = keys_q & ~keys_prev_q;
    fall     = ~keys_q & keys_prev_q;
    rise_low = '0;
    for (int i = 15; i >= 0; i--) begin
      if (rise[i]) rise_low = 4'(i);
    end
  end

  // Wait FSM
  always_comb begin
    state_d    = state_q;
    cap_d      = cap_q;
    wait_key_d = wait_key_q;
    unique case (state_q)
      StIdle: begin
        if (wait_req) state_d = StArmed;
      end
      StArmed: begin
        if (|rise) begin
          cap_d   = rise_low;
          state_d = StHeld;
        end
      end
      StHeld: begin
        if (fall[cap_q]) begin
          wait_key_d = cap_q;
          state_d    = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q       <= '0;
      keys_q      <= '0;
      keys_prev_q <= '0;
      cap_q       <= '0;
      wait_key_q  <= '0;
      state_q     <= StIdle;
      for (int i = 0; i < 16; i++) cnt_q[i] <= '0;
    end else begin
      div_q       <= div_d;
      keys_q      <= keys_d;
      keys_prev_q <= keys_q;
      cap_q       <= cap_d;
      wait_key_q  <= wait_key_d;
      state_q     <= state_d;
      for (int i = 0; i < 16; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  always_comb begin
    keys          = keys_q;
    query_pressed = keys_q[query_key];
    wait_busy     = (state_q == StArmed) || (state_q == StHeld);
    wait_done     = (state_q == StDone);
    wait_key      = wait_key_q;
  end

endmodule

// File: tb/tb_keypad_events.sv
// Bench for keypad_events: directed debounce timing plus a scoreboard of
// expected wait completions checked whenever wait_done pulses.
module tb_keypad_events;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] matrix;
  logic [15:0] keys;
  logic [3:0]  query_key;
  logic        query_pressed;
  logic        wait_req;
  logic        wait_busy;
  logic        wait_done;
  logic [3:0]  wait_key;

  int checks   = 0;
  int failures = 0;
  logic [3:0] exp_q [$];

  keypad_events #(
    .SAMPLE_DIV    (4),
    .STABLE_SAMPLES(3)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .matrix       (matrix),
    .keys         (keys),
    .query_key    (query_key),
    .query_pressed(query_pressed),
    .wait_req     (wait_req),
    .wait_busy    (wait_busy),
    .wait_done    (wait_done),
    .wait_key     (wait_key)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic arm();
    wait_req = 1'b1;
    step(1);
    wait_req = 1'b0;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    check("drain", exp_q.size(), 0);
  endtask

  // Completion monitor: every wait_done must match a queued expectation.
  always @(negedge clk) begin
    if (!reset && wait_done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        check("wait_key", wait_key, exp_q.pop_front());
      end
    end
  end

  initial begin
    reset     = 1'b1;
    matrix    = '0;
    query_key = '0;
    wait_req  = 1'b0;
    step(3);
    check("rst_keys", keys, 16'h0000);
    check("rst_busy", wait_busy, 0);
    check("rst_key", wait_key, 0);

    // 1. Clean press: keys flips exactly at cycle 12.
    reset  = 1'b0;
    matrix = 16'h0020;
    for (int n = 0; n <= 11; n++) begin
      step(1);
      if (n < 11) check("press_early", keys, 16'h0000);
      else        check("press_edge", keys, 16'h0020);
    end
    query_key = 4'd5;
    #1 check("query5", query_pressed, 1);
    query_key = 4'd4;
    #1 check("query4", query_pressed, 0);

    // 2. Glitch of two samples on key 3 is rejected.
    matrix = 16'h0028;
    step(8);
    check("glitch_cnt_mid", dut.cnt_q[3], 2);
    matrix = 16'h0020;
    step(4);
    check("glitch_cnt", dut.cnt_q[3], 0);
    check("glitch_keys", keys, 16'h0020);

    // 3. Full wait: press A, press 2 while held, release A.
    matrix = 16'h0000;
    step(16);
    check("released", keys, 16'h0000);
    arm();
    check("busy_armed", wait_busy, 1);
    matrix = 16'h0400;
    step(16);
    matrix = 16'h0404;
    step(16);
    check("busy_held", wait_busy, 1);
    exp_q.push_back(4'hA);
    matrix = 16'h0004;
    drain(40);
    step(1);
    check("busy_after3", wait_busy, 0);
    check("key_hold3", wait_key, 4'hA);

    // 4. Key pressed before arming does not qualify.
    matrix = 16'h0000;
    step(16);
    matrix = 16'h0080;
    step(16);
    arm();
    matrix = 16'h0000;
    step(16);
    check("preheld_busy", wait_busy, 1);
    matrix = 16'h0080;
    step(16);
    exp_q.push_back(4'h7);
    matrix = 16'h0000;
    drain(40);

    // 5. Simultaneous rise picks the lowest index; re-arm in HELD is ignored.
    arm();
    matrix = 16'h1010;
    step(16);
    check("cap", dut.cap_q, 4);
    matrix = 16'h0010;
    step(16);
    check("other_release", wait_busy, 1);
    arm();
    check("req_in_held", wait_busy, 1);
    exp_q.push_back(4'h4);
    matrix = 16'h0000;
    drain(40);
    step(20);
    check("idle_after5", wait_busy, 0);

    // 6. Reset while HELD.
    arm();
    matrix = 16'h0200;
    step(16);
    check("held6", wait_busy, 1);
    reset     = 1'b1;
    matrix    = 16'h0000;
    query_key = 4'd9;
    step(1);
    check("rst6_keys", keys, 16'h0000);
    check("rst6_busy", wait_busy, 0);
    check("rst6_done", wait_done, 0);
    check("rst6_key", wait_key, 0);
    check("rst6_query", query_pressed, 0);
    reset = 1'b0;
    step(2);
    arm();
    check("rearm6", wait_busy, 1);
    matrix = 16'h0002;
    step(16);
    exp_q.push_back(4'h1);
    matrix = 16'h0000;
    drain(40);
    step(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/keypad_events.md
# keypad_events

Debounces the raw 16-key matrix produced by the keypad scanner and turns it into clean key state plus the key-wait handshake the CPU core needs. Sits directly downstream of the scanner, which refreshes one row of `matrix` per clock, and upstream of the instruction executor. It serves skip-if-pressed queries (EX9E/EXA1) and the blocking wait-for-key instruction (FX0A).

## Interface
- `SAMPLE_DIV`, default 1024: clocks between debounce samples; legal range ≥ 4.
- `STABLE_SAMPLES`, default 4: consecutive differing samples needed to accept a change; legal range ≥ 1.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `matrix` in 16: raw key states from the scanner; bit i is hex key i, 1 means pressed.
- `keys` out 16: debounced key state.
- `query_key` in 4: key index for the pressed query.
- `query_pressed` out 1: combinational, equal to `keys[query_key]`.
- `wait_req` in 1: single-cycle pulse that arms a key wait.
- `wait_busy` out 1: high in ARMED and HELD.
- `wait_done` out 1: single-cycle pulse when a wait completes.
- `wait_key` out 4: completed key index; holds its value until the next completion.

## Operation
- **Sample divider**
  - `div` counts 0..SAMPLE_DIV-1 and wraps.
  - `tick` is high in the cycle where `div == SAMPLE_DIV-1`.
- **Per-key debounce** (16 independent saturating counters, width clog2(STABLE_SAMPLES)+1). On each `tick`:
  - If `matrix[i] == keys[i]`, `cnt[i] <= 0`.
  - Else, if `cnt[i] == STABLE_SAMPLES-1`, `keys[i] <= matrix[i]` and `cnt[i] <= 0`.
  - Else `cnt[i] <= cnt[i]+1`.
  - Any agreeing sample discards partial progress, so a one-tick glitch never changes `keys`.
  - Between ticks, `matrix` is ignored.
- **Edge detect**
  - `keys_d` is `keys` delayed one cycle.
  - `rise = keys & ~keys_d`, `fall = ~keys & keys_d`.
- **Wait FSM**, states IDLE, ARMED, HELD, DONE:
  - IDLE: `wait_req` → ARMED.
  - ARMED: any `rise` bit set → capture the lowest set index into `cap`, go to HELD. Keys already held when arming do not qualify; only a new debounced press does.
  - HELD: `fall[cap]` → `wait_key <= cap`, go to DONE. Presses and releases of other keys are ignored.
  - DONE: `wait_done` = 1 for exactly this cycle, then → IDLE.
  - `wait_req` outside IDLE (including in DONE) is ignored; there is no cancel.
- **Reset** (any cycle, including mid-wait):
  - `div`, `cnt`, `keys`, `keys_d` and `cap` clear to 0.
  - FSM goes to IDLE; `wait_busy`, `wait_done` = 0; `wait_key` = 0.
  - `query_pressed` follows `keys`, so it reads 0.

## Timing
- Cycle 0 is the first rising edge with `reset` low. `div` is 0 at cycle 0, and the first `tick` is at cycle SAMPLE_DIV-1.
- **Debounce latency:** a `matrix` change stable before tick k appears on `keys` one cycle after tick k+STABLE_SAMPLES-1.
- `rise`/`fall` are valid one cycle after `keys` changes.
- **FSM reaction:**
  - The ARMED→HELD transition happens on the clock edge in the cycle `rise` is high.
  - `wait_done` is high in the cycle after `fall[cap]` is seen.
- **Wait minimum:** release-to-`wait_done` takes at least STABLE_SAMPLES ticks plus 2 cycles.
- **Simultaneous events:**
  - A press and a release of different keys on the same tick are handled independently.
  - A `rise` in the same cycle as `wait_req` (FSM still IDLE) is not captured.
- `query_pressed` has zero latency from `query_key`.

## Test plan
1. **Clean press.** SAMPLE_DIV=4, STABLE_SAMPLES=3; `matrix=16'h0020` from cycle 0. Required: `keys` = 16'h0000 through cycle 11 and 16'h0020 at cycle 12; `query_key=5` → `query_pressed=1`.
2. **Glitch rejection.** Same parameters; `matrix[3]` high only during the ticks at cycles 3 and 7, low at cycle 11. Required: `keys[3]` stays 0 and `cnt[3]` returns to 0.
3. **Full wait.** Pulse `wait_req` → `wait_busy=1`. Debounced press of key 0xA, then press of key 2 while held, then release of 0xA. Required: `wait_done` is a single pulse with `wait_key=4'hA`, then `wait_busy=0`.
4. **Pre-held key ignored.** Key 7 held debounced before arming, then released and pressed again. Required: completion occurs only after the second press/release, with `wait_key=7`.
5. **Simultaneous press.** Keys 0xC and 0x4 rise in the same cycle while ARMED. Required: `cap=4`; releasing 0xC has no effect; releasing 4 gives `wait_key=4`. A `wait_req` issued while HELD is ignored, and there is no second `wait_done`.
6. **Reset mid-wait.** Assert `reset` in HELD. Required: next cycle `keys=0`, `wait_busy=0`, `wait_done=0`, `wait_key=0`; a subsequent `wait_req` arms normally.
